// File: rtl/axi_dbg_pkg.sv
// Shared types and constants for the AXI4-Lite debug bridge.
// FSM state enum, command/reply bytes, AXI response codes.
package axi_dbg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_GET_STRB,
    S_AXI_WR,
    S_AXI_B,
    S_AXI_AR,
    S_AXI_R,
    S_SEND
  } state_t;

  localparam logic [7:0] CMD_WR     = 8'h57;
  localparam logic [7:0] CMD_RD     = 8'h52;
  localparam logic [7:0] RSP_BADCMD = 8'hEE;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_dbg_txbuf.sv
// Reply buffer: up to 5 bytes, shifted out LSB byte first.
// Ports: load/load_data/load_cnt, tx_byte/tx_valid/tx_ready, last.
module axi_dbg_txbuf
  import axi_dbg_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        load,
  input  logic [39:0] load_data,
  input  logic [2:0]  load_cnt,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last
);

  logic [39:0] sh_q;
  logic [2:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sh_q  <= load_data;
      cnt_q <= load_cnt;
    end else if (tx_valid && tx_ready) begin
      sh_q  <= {8'h00, sh_q[39:8]};
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign tx_byte  = sh_q[7:0];
  assign tx_valid = (cnt_q != 3'd0);
  assign last     = (cnt_q == 3'd1);

endmodule

// File: rtl/axi_lite_dbg_master.sv
// Byte-stream driven AXI4-Lite debug master (host peek/poke).
// Ports: rx byte strobe in, tx byte handshake out, AXI4-Lite master.
// Optional inter-byte timeout: define AXI_DBG_TIMEOUT_EN.
module axi_lite_dbg_master
  import axi_dbg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  state_t      state, next;
  logic [1:0]  cnt_q;
  logic        is_wr_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic        aw_done, w_done;
  logic        aw_ok, w_ok;
  logic        txb_load, txb_last;
  logic [39:0] txb_data;
  logic [2:0]  txb_cnt;
  logic        tmo_hit;

`ifdef AXI_DBG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          in_get;

  assign in_get = (state == S_GET_ADDR) ||
                  (state == S_GET_DATA) ||
                  (state == S_GET_STRB);

  always_ff @(posedge clk) begin
    if (!nrst || rx_valid || !in_get)
      tmo_q <= '0;
    else
      tmo_q <= tmo_q + TW'(1);
  end

  // a byte arriving on the expiry cycle still counts
  assign tmo_hit = in_get && !rx_valid &&
                   (tmo_q == TW'(TIMEOUT_CYCLES));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  assign awvalid = (state == S_AXI_WR) && !aw_done;
  assign wvalid  = (state == S_AXI_WR) && !w_done;
  assign aw_ok   = aw_done || (awvalid && awready);
  assign w_ok    = w_done || (wvalid && wready);
  assign bready  = (state == S_AXI_B);
  assign arvalid = (state == S_AXI_AR);
  assign rready  = (state == S_AXI_R);
  assign awaddr  = addr_q[ADDR_WIDTH-1:0];
  assign araddr  = addr_q[ADDR_WIDTH-1:0];
  assign wdata   = data_q[DATA_WIDTH-1:0];
  assign wstrb   = strb_q;
  assign awprot  = 3'b000;
  assign arprot  = 3'b000;

  always_comb begin
    next     = state;
    txb_load = 1'b0;
    txb_data = '0;
    txb_cnt  = 3'd1;
    unique case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
            next = S_GET_ADDR;
          end else begin
            next     = S_SEND;
            txb_load = 1'b1;
            txb_data = {32'h0, RSP_BADCMD};
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_valid && cnt_q == 2'd3)
          next = is_wr_q ? S_GET_DATA : S_AXI_AR;
      end
      S_GET_DATA: begin
        if (rx_valid && cnt_q == 2'd3)
          next = S_GET_STRB;
      end
      S_GET_STRB: begin
        if (rx_valid)
          next = S_AXI_WR;
      end
      S_AXI_WR: begin
        if (aw_ok && w_ok)
          next = S_AXI_B;
      end
      S_AXI_B: begin
        if (bvalid) begin
          next     = S_SEND;
          txb_load = 1'b1;
          txb_data = {32'h0, 6'b0, bresp};
        end
      end
      S_AXI_AR: begin
        if (arready)
          next = S_AXI_R;
      end
      S_AXI_R: begin
        if (rvalid) begin
          next     = S_SEND;
          txb_load = 1'b1;
          txb_data = {rdata[31:0], 6'b0, rresp};
          txb_cnt  = 3'd5;
        end
      end
      S_SEND: begin
        if (tx_valid && tx_ready && txb_last)
          next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
    if (tmo_hit)
      next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= S_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= next;
      if (state == S_IDLE) begin
        cnt_q <= '0;
        if (rx_valid)
          is_wr_q <= (rx_byte == CMD_WR);
      end
      // fields fill LSB first by shifting in at the top
      if (rx_valid && state == S_GET_ADDR) begin
        addr_q <= {rx_byte, addr_q[31:8]};
        cnt_q  <= cnt_q + 2'd1;
      end
      if (rx_valid && state == S_GET_DATA) begin
        data_q <= {rx_byte, data_q[31:8]};
        cnt_q  <= cnt_q + 2'd1;
      end
      if (rx_valid && state == S_GET_STRB)
        strb_q <= rx_byte[3:0];
      aw_done <= (next == S_AXI_WR) && aw_ok;
      w_done  <= (next == S_AXI_WR) && w_ok;
    end
  end

  axi_dbg_txbuf u_txbuf (
    .clk       (clk),
    .nrst      (nrst),
    .load      (txb_load),
    .load_data (txb_data),
    .load_cnt  (txb_cnt),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .last      (txb_last)
  );

endmodule

// File: tb/tb_axi_lite_dbg_master.sv
// Directed bench for axi_lite_dbg_master with a reactive AXI slave.
// Timeout scenario runs when AXI_DBG_TIMEOUT_EN is defined.
module tb_axi_lite_dbg_master;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] awaddr, araddr, wdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;

  always #5 clk = ~clk;

  axi_lite_dbg_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .nrst(nrst),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;

  // slave knobs and observations
  int          aw_dly = 0, w_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int          aw_wait = 0, w_wait = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic        aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  logic [31:0] aw_seen = 0, w_seen = 0, ar_seen = 0;
  logic [3:0]  strb_seen = 0;
  logic        tx_stall = 0;
  logic [7:0]  txq[$];
  int          stab_err = 0;
  logic        pend_hold = 0;
  logic [7:0]  last_byte = 0;

  // slave inputs change on the falling edge; a handshake seen here
  // completes at the next rising edge
  always @(negedge clk) begin
    if (!nrst) begin
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; rvalid = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_wait = 0; w_wait = 0; pend_hold = 0;
      tx_ready = !tx_stall;
    end else begin
      bvalid = b_pend;
      bresp  = bresp_cfg;
      if (bvalid && bready) b_pend = 0;
      rvalid = r_pend;
      rdata  = r_pend ? rdata_cfg : 32'h0;
      rresp  = rresp_cfg;
      if (rvalid && rready) r_pend = 0;
      awready = awvalid && (aw_wait >= aw_dly);
      if (awvalid && !awready) aw_wait++;
      if (awvalid && awready) begin
        aw_cnt++; aw_seen = awaddr; aw_wait = 0; aw_got = 1;
      end
      wready = wvalid && (w_wait >= w_dly);
      if (wvalid && !wready) w_wait++;
      if (wvalid && wready) begin
        w_cnt++; w_seen = wdata; strb_seen = wstrb;
        w_wait = 0; w_got = 1;
      end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_pend = 1;
      end
      arready = arvalid;
      if (arvalid) begin
        ar_cnt++; ar_seen = araddr; r_pend = 1;
      end
      tx_ready = !tx_stall;
      if (pend_hold && (!tx_valid || tx_byte !== last_byte))
        stab_err++;
      pend_hold = tx_valid && !tx_ready;
      last_byte = tx_byte;
      if (tx_valid && tx_ready) txq.push_back(tx_byte);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int base, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (txq.size() >= base + n) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, tx_valid}
        !== 6'b0) begin
      errors++;
      $display("FAIL reset_valids got %b want 000000",
        {awvalid, wvalid, arvalid, bready, rready, tx_valid});
    end
    checks++;
    if (awaddr !== 32'h0) begin
      errors++; $display("FAIL reset_awaddr got %h want 0", awaddr);
    end
    checks++;
    if (araddr !== 32'h0) begin
      errors++; $display("FAIL reset_araddr got %h want 0", araddr);
    end
    checks++;
    if (wdata !== 32'h0) begin
      errors++; $display("FAIL reset_wdata got %h want 0", wdata);
    end
    checks++;
    if (wstrb !== 4'h0) begin
      errors++; $display("FAIL reset_wstrb got %h want 0", wstrb);
    end
    checks++;
    if (tx_byte !== 8'h00) begin
      errors++; $display("FAIL reset_tx_byte got %h want 0", tx_byte);
    end
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    logic [7:0] f[10] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h00,
                          8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h0F};
    int base = txq.size();
    int a0 = aw_cnt;
    int w0 = w_cnt;
    bit ok;
    foreach (f[i]) send_byte(f[i]);
    wait_tx(1, base, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wr_reply got none want 1 byte");
    end
    checks++;
    if (aw_seen !== 32'h0) begin
      errors++; $display("FAIL wr_awaddr got %h want 0", aw_seen);
    end
    checks++;
    if (w_seen !== 32'hC33C5AA5) begin
      errors++;
      $display("FAIL wr_wdata got %h want c33c5aa5", w_seen);
    end
    checks++;
    if (strb_seen !== 4'hF) begin
      errors++; $display("FAIL wr_wstrb got %h want f", strb_seen);
    end
    checks++;
    if (aw_cnt - a0 != 1 || w_cnt - w0 != 1) begin
      errors++;
      $display("FAIL wr_hs_count got aw=%0d w=%0d want 1 1",
        aw_cnt - a0, w_cnt - w0);
    end
    checks++;
    if (txq.size() != base + 1 || txq[base] !== 8'h00) begin
      errors++;
      $display("FAIL wr_tx got n=%0d b=%h want n=1 b=00",
        txq.size() - base, txq[base]);
    end
  endtask

  task automatic test_read;
    logic [7:0] f[5] = '{8'h52, 8'h04, 8'h10, 8'h00, 8'h00};
    logic [7:0] e[5] = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int base = txq.size();
    int r0 = ar_cnt;
    int a0 = aw_cnt;
    bit ok;
    rdata_cfg = 32'hDEADBEEF;
    rresp_cfg = 2'b00;
    foreach (f[i]) send_byte(f[i]);
    wait_tx(5, base, ok);
    #1;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rd_reply got %0d bytes want 5",
        txq.size() - base);
    end
    checks++;
    if (ar_seen !== 32'h00001004) begin
      errors++; $display("FAIL rd_araddr got %h want 1004", ar_seen);
    end
    checks++;
    if (ar_cnt - r0 != 1 || aw_cnt != a0) begin
      errors++; $display("FAIL rd_hs_count got ar=%0d aw=%0d want 1 0",
        ar_cnt - r0, aw_cnt - a0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (txq[base + i] !== e[i]) begin
        errors++; $display("FAIL rd_tx%0d got %h want %h",
          i, txq[base + i], e[i]);
      end
    end
  endtask

  task automatic test_skew;
    logic [7:0] f[10] = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h00,
                          8'h44, 8'h33, 8'h22, 8'h11, 8'h03};
    int base = txq.size();
    int w0 = w_cnt;
    bit ok = 0;
    aw_dly = 3;
    w_dly = 0;
    bresp_cfg = 2'b10;
    foreach (f[i]) send_byte(f[i]);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (w_cnt != w0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL skew_w_hs got none want 1");
    end
    checks++;
    if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
      errors++; $display("FAIL skew_valids got w=%b aw=%b want 0 1",
        wvalid, awvalid);
    end
    wait_tx(1, base, ok);
    #1;
    checks++;
    if (!ok || txq[base] !== 8'h02) begin
      errors++; $display("FAIL skew_tx got %h want 02", txq[base]);
    end
    checks++;
    if (aw_seen !== 32'h40 || w_seen !== 32'h11223344 ||
        strb_seen !== 4'h3) begin
      errors++;
      $display("FAIL skew_fields got %h %h %h want 40 11223344 3",
        aw_seen, w_seen, strb_seen);
    end
    aw_dly = 0;
    bresp_cfg = 2'b00;
  endtask

  task automatic test_badcmd;
    logic [7:0] f[5] = '{8'h52, 8'h00, 8'h20, 8'h00, 8'h00};
    logic [7:0] e[5] = '{8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    int base = txq.size();
    int a0 = aw_cnt;
    int r0 = ar_cnt;
    bit ok;
    send_byte(8'h33);
    wait_tx(1, base, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || txq[base] !== 8'hEE || txq.size() != base + 1) begin
      errors++; $display("FAIL bad_tx got %h n=%0d want ee n=1",
        txq[base], txq.size() - base);
    end
    checks++;
    if (aw_cnt != a0 || ar_cnt != r0) begin
      errors++; $display("FAIL bad_axi got aw=%0d ar=%0d want 0 0",
        aw_cnt - a0, ar_cnt - r0);
    end
    base = txq.size();
    rdata_cfg = 32'h12345678;
    foreach (f[i]) send_byte(f[i]);
    wait_tx(5, base, ok);
    #1;
    checks++;
    if (!ok || ar_seen !== 32'h2000) begin
      errors++; $display("FAIL bad_next_ar got %h want 2000", ar_seen);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (txq[base + i] !== e[i]) begin
        errors++; $display("FAIL bad_next_tx%0d got %h want %h",
          i, txq[base + i], e[i]);
      end
    end
  endtask

  task automatic test_tx_stall;
    logic [7:0] f[5] = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
    logic [7:0] e[5] = '{8'h03, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    int base = txq.size();
    bit ok;
    rdata_cfg = 32'hCAFEF00D;
    rresp_cfg = 2'b11;
    foreach (f[i]) send_byte(f[i]);
    wait_tx(2, base, ok);
    tx_stall = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (!ok || txq.size() != base + 2 || tx_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hold got n=%0d v=%b want 2 1",
        txq.size() - base, tx_valid);
    end
    tx_stall = 1'b0;
    wait_tx(5, base, ok);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (!ok || txq.size() != base + 5) begin
      errors++; $display("FAIL stall_count got %0d want 5",
        txq.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (txq[base + i] !== e[i]) begin
        errors++; $display("FAIL stall_tx%0d got %h want %h",
          i, txq[base + i], e[i]);
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL stall_stable got %0d want 0", stab_err);
    end
    rresp_cfg = 2'b00;
  endtask

  task automatic test_partial;
    int base = txq.size();
    int r0 = ar_cnt;
    bit ok;
    send_byte(8'h52);
    send_byte(8'h04);
    repeat (TMO + 6) @(posedge clk);
`ifdef AXI_DBG_TIMEOUT_EN
    send_byte(8'h52);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_tx(5, base, ok);
    #1;
    checks++;
    if (!ok || ar_cnt - r0 != 1 || ar_seen !== 32'h1234) begin
      errors++; $display("FAIL tmo_ar got n=%0d a=%h want 1 1234",
        ar_cnt - r0, ar_seen);
    end
`else
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_tx(5, base, ok);
    #1;
    checks++;
    if (!ok || ar_cnt - r0 != 1 || ar_seen !== 32'h4) begin
      errors++; $display("FAIL wait_ar got n=%0d a=%h want 1 4",
        ar_cnt - r0, ar_seen);
    end
`endif
  endtask

  task automatic test_reset_mid;
    send_byte(8'h57);
    for (int i = 0; i < 8; i++) send_byte(8'h00);
    aw_dly = 50;
    w_dly = 50;
    send_byte(8'h0F);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({awvalid, wvalid} !== 2'b00) begin
      errors++; $display("FAIL mid_reset got %b want 00",
        {awvalid, wvalid});
    end
    aw_dly = 0;
    w_dly = 0;
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_skew();
    test_badcmd();
    test_tx_stall();
    test_partial();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_dbg_master.md
# axi_lite_dbg_master

Byte-stream-driven AXI4-Lite master (host debug bridge). Parses read/write commands arriving as bytes from a UART receiver, issues single AXI4-Lite transactions into the crossbar as a second master, and returns status and read data as bytes to a UART transmitter. Gives a host peek/poke access to GPIO, REG, UART and CLINT MMIO space without CPU involvement.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (fixed 32; 4 data bytes per command)
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles
- clk  input  1  clock
- nrst  input  1  reset, synchronous, active-low
- rx_byte  input  8  received byte
- rx_valid  input  1  one-cycle strobe, rx_byte valid; no backpressure
- tx_byte  output  8  byte to transmit
- tx_valid  output  1  tx_byte valid; held until tx_ready
- tx_ready  input  1  transmitter accepts byte
- awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master channels, widths per ADDR_WIDTH/DATA_WIDTH; awprot = arprot = 3'b000

## Operation
- Command frames, multi-byte fields little-endian:
  - write: 0x57, addr[4], data[4], strb[1] (low nibble used)
  - read: 0x52, addr[4]
- Replies:
  - write: one byte {6'b0, bresp}
  - read: {6'b0, rresp}, then rdata[4] LSB first
  - unknown command byte: 0xEE
- FSM: IDLE -> GET_ADDR (4 bytes) -> {write: GET_DATA (4) -> GET_STRB (1) -> AXI_WR -> AXI_B | read: AXI_AR -> AXI_R} -> SEND -> IDLE.
  - Unknown command: IDLE -> SEND (0xEE) -> IDLE.
  - 2-bit byte counter shared by GET_ADDR and GET_DATA.
- AXI_WR:
  - awvalid and wvalid rise together and each is held until its own ready.
  - Arbitrary aw/w acceptance skew, including same-cycle.
  - Advance to AXI_B once both are accepted.
- AXI_B: bready = 1; on bvalid, latch bresp and go to SEND.
- AXI_AR: arvalid held until arready.
- AXI_R: rready = 1; on rvalid, latch rdata and rresp and go to SEND.
- SEND:
  - 5-byte buffer, count 1 or 5; each byte presented until tx_valid & tx_ready.
  - Return to IDLE after the last handshake.
- rx_valid strobes outside IDLE/GET_* states are discarded.
- AXI fields (awaddr, wdata, wstrb, araddr) stay stable while their valid is high.

## Timing
- Reset: every valid/ready output is 0; awaddr, araddr, wdata, wstrb, tx_byte are 0; state IDLE.
- Byte capture: field register updates the cycle after the rx_valid strobe.
- awvalid/wvalid (or arvalid) are asserted the cycle after the last command byte is captured.
- tx_valid rises the cycle after the b or r handshake.
- Next byte is presented the cycle after each tx handshake; tx_ready held high gives one byte per cycle.
- No AXI timeout: a slave that never responds stalls the bridge until reset.
- Reset mid-transaction aborts the transaction; all valids drop on the next edge.

## Configuration
- AXI_DBG_TIMEOUT_EN defined:
  - Counter (width $clog2(TIMEOUT_CYCLES+1)) clears on every rx_valid.
  - If in GET_ADDR, GET_DATA or GET_STRB and the count reaches TIMEOUT_CYCLES, the partial frame is dropped and the FSM goes to IDLE; no reply.
- AXI_DBG_TIMEOUT_EN undefined: no counter; a partial frame waits indefinitely.

## Structure
- Package axi_dbg_pkg: state enum, CMD_WR = 8'h57, CMD_RD = 8'h52, RSP_BADCMD = 8'hEE, AXI resp codes (OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11).
- Sub-module axi_dbg_txbuf: 5-byte load/shift buffer with remaining-count and the tx_valid/tx_ready handshake; loaded by the FSM on entry to SEND.

## Test plan
- Write frame 57 00 00 00 00 A5 5A 3C C3 0F -> awaddr 0x0000_0000, wdata 0xC33C5AA5, wstrb 4'hF, exactly one AW and one W handshake, tx 0x00.
- Read frame 52 04 10 00 00, slave returns 0xDEADBEEF OKAY -> araddr 0x0000_1004, tx 00 EF BE AD DE in order.
- Slave accepts W 3 cycles before AW, bresp SLVERR -> wvalid drops after its handshake, awvalid held, tx 0x02.
- Unknown byte 0x33 -> tx 0xEE, no AXI activity; a following valid read frame is serviced normally.
- tx_ready low 10 cycles mid-reply -> tx_byte/tx_valid held stable, no byte lost or duplicated.
- With AXI_DBG_TIMEOUT_EN: send 52 04, idle TIMEOUT_CYCLES+1 cycles, then a full read frame -> only one AR issued, with the new address.
